// File: rtl/mdu_sched_pkg.sv
// Shared encodings and default latencies for the multiply/divide issue scheduler.
package mdu_sched_pkg;

  typedef enum logic [2:0] {
    OP_READ_HI  = 3'b000,
    OP_READ_LO  = 3'b001,
    OP_WRITE_HI = 3'b010,
    OP_WRITE_LO = 3'b011,
    OP_SMUL     = 3'b100,
    OP_UMUL     = 3'b101,
    OP_SDIV     = 3'b110,
    OP_UDIV     = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } sched_state_e;

  localparam int DEF_MUL_LATENCY = 5;
  localparam int DEF_DIV_LATENCY = 10;

  function automatic logic is_mul(input logic [2:0] op);
    return (op == OP_SMUL) || (op == OP_UMUL);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_SDIV) || (op == OP_UDIV);
  endfunction

endpackage

// File: rtl/mdu_latency_counter.sv
// Loadable 5-bit down-counter; idles at zero so o_done doubles as "nothing pending".
module mdu_latency_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_load,
  input  logic [4:0] i_value,
  output logic       o_done
);

  logic [4:0] r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)              r_cnt <= '0;
    else if (i_load)        r_cnt <= i_value;
    else if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
  end

  assign o_done = (r_cnt == 5'd0);

endmodule

// File: rtl/mdu_scheduler.sv
// Issue scheduler for the iterative multiply/divide unit: stalls ID while an op
// is in flight and emits a registered start pulse aligned with EX.
module mdu_scheduler
  import mdu_sched_pkg::*;
#(
  parameter int MUL_LATENCY = DEF_MUL_LATENCY,
  parameter int DIV_LATENCY = DEF_DIV_LATENCY
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        mdu_start,
  output logic [2:0]  mdu_op,
  output logic [15:0] stall_cycles
);

  sched_state_e r_state;
  logic         r_busy;
  logic         r_start;
  logic [2:0]   r_op;
  logic [15:0]  r_stall_cnt;

  logic       w_live, w_accept, w_start_mul, w_start_div, w_cnt_done;
  logic [4:0] w_load_val;

  // stall depends only on ports and the registered busy flag
  assign w_live      = req_valid & ~flush;
  assign w_accept    = w_live & ~r_busy;
  assign stall       = w_live & r_busy;
  assign w_start_mul = w_accept & is_mul(req_op);
  assign w_start_div = w_accept & is_div(req_op);
  assign w_load_val  = w_start_div ? 5'(DIV_LATENCY - 1) : 5'(MUL_LATENCY - 1);

  mdu_latency_counter u_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_start_mul | w_start_div),
    .i_value (w_load_val),
    .o_done  (w_cnt_done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_start     <= 1'b0;
      r_op        <= 3'b000;
      r_stall_cnt <= '0;
    end else begin
      r_start <= w_accept;
      if (w_accept) r_op <= req_op;
      if (stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      case (r_state)
        ST_IDLE: begin
          if (w_start_mul) begin
            r_state <= ST_MUL;
            r_busy  <= 1'b1;
          end else if (w_start_div) begin
            r_state <= ST_DIV;
            r_busy  <= 1'b1;
          end
        end
        ST_MUL, ST_DIV: begin
          if (w_cnt_done) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign mdu_start    = r_start;
  assign mdu_op       = r_op;
  assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_mdu_scheduler.sv
// Self-checking bench for mdu_scheduler against a remaining-busy-cycles model.
module tb_mdu_scheduler;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        mdu_start;
  logic [2:0]  mdu_op;
  logic [15:0] stall_cycles;

  mdu_scheduler #(.MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .flush        (flush),
    .stall        (stall),
    .busy         (busy),
    .mdu_start    (mdu_start),
    .mdu_op       (mdu_op),
    .stall_cycles (stall_cycles)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // model: cycles of busy still owed, last start/op, stall counter
  int       m_rem;
  bit       m_start;
  bit [2:0] m_op;
  int       m_cnt;
  bit       m_stall;
  logic     obs_stall;

  task automatic model_reset();
    m_rem = 0; m_start = 0; m_op = 3'b000; m_cnt = 0; m_stall = 0;
  endtask

  // one clock: drive at posedge+1, sample stall mid-cycle, advance model, return at posedge+1
  task automatic cyc(input bit v, input bit [2:0] op, input bit f);
    bit acc;
    req_valid = v; req_op = op; flush = f;
    #3;
    obs_stall = stall;
    m_stall = v && !f && (m_rem != 0);
    acc     = v && !f && (m_rem == 0);
    @(posedge clock);
    if (m_stall && m_cnt != 65535) m_cnt++;
    m_start = acc;
    if (acc) m_op = op;
    if (m_rem > 0) m_rem--;
    if (acc && op[2]) m_rem = op[1] ? DIV_LAT : MUL_LAT;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b1; req_op = 3'b100; flush = 1'b0;
    model_reset();
    #2;
    n_vec++;
    if (busy !== 1'b0 || mdu_start !== 1'b0 || mdu_op !== 3'b000 ||
        stall_cycles !== 16'h0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b start=%b op=%b cnt=%0h stall=%b want all zero",
               busy, mdu_start, mdu_op, stall_cycles, stall);
    end
    @(posedge clock); #1;
    reset = 1'b0; req_valid = 1'b0;
  endtask

  task automatic test_mul();
    int nb;
    cyc(1, 3'b100, 0);
    n_vec++;
    if (mdu_start !== 1'b1 || mdu_op !== 3'b100) begin
      n_err++;
      $display("FAIL mul_start: got start=%b op=%b want 1/100", mdu_start, mdu_op);
    end
    nb = (busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 7; i++) begin
      cyc(0, 3'($urandom), 0);
      n_vec++;
      if (mdu_start !== 1'b0) begin
        n_err++;
        $display("FAIL mul_pulse_width: got start=%b want 0 at cycle %0d", mdu_start, i);
      end
      if (busy === 1'b1) nb++;
    end
    n_vec++;
    if (nb != MUL_LAT) begin
      n_err++;
      $display("FAIL mul_busy_len: got %0d want %0d", nb, MUL_LAT);
    end
    n_vec++;
    if (stall_cycles !== 16'd0) begin
      n_err++;
      $display("FAIL mul_stall_cnt: got %0d want 0", stall_cycles);
    end
  endtask

  task automatic test_div_stall();
    int ns, acc_at;
    cyc(1, 3'b110, 0);
    ns = 0; acc_at = -1;
    for (int i = 0; i < 20 && acc_at < 0; i++) begin
      cyc(1, 3'b000, 0);
      n_vec++;
      if (obs_stall !== logic'(m_stall)) begin
        n_err++;
        $display("FAIL div_stall_cyc: got %b want %b at cycle %0d", obs_stall, m_stall, i);
      end
      if (obs_stall === 1'b1) ns++;
      if (mdu_start === 1'b1) acc_at = i;
    end
    n_vec++;
    if (ns != DIV_LAT || acc_at != DIV_LAT) begin
      n_err++;
      $display("FAIL div_stall_len: got stalls=%0d accept_idx=%0d want %0d/%0d",
               ns, acc_at, DIV_LAT, DIV_LAT);
    end
    n_vec++;
    if (stall_cycles !== 16'd10 || mdu_op !== 3'b000 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL div_read_accept: got cnt=%0d op=%b busy=%b want 10/000/0",
               stall_cycles, mdu_op, busy);
    end
    cyc(0, 3'b000, 0);
  endtask

  task automatic test_back_to_back();
    int t1, t2, starts, b1, b2;
    t1 = -1; t2 = -1; starts = 0; b1 = 0; b2 = 0;
    for (int t = 0; t < 25; t++) begin
      cyc(starts < 2, (starts == 0) ? 3'b101 : 3'b111, 0);
      if (mdu_start === 1'b1) begin
        if (starts == 0) t1 = t; else t2 = t;
        if (starts == 1) begin
          n_vec++;
          if (mdu_op !== 3'b111) begin
            n_err++;
            $display("FAIL b2b_op: got %b want 111", mdu_op);
          end
        end
        starts++;
      end
      if (busy === 1'b1) begin
        if (t2 < 0) b1++; else b2++;
      end
    end
    n_vec++;
    if (t1 < 0 || t2 - t1 != MUL_LAT + 1) begin
      n_err++;
      $display("FAIL b2b_spacing: got t1=%0d t2=%0d want gap %0d", t1, t2, MUL_LAT + 1);
    end
    n_vec++;
    if (b1 != MUL_LAT || b2 != DIV_LAT) begin
      n_err++;
      $display("FAIL b2b_busy: got %0d/%0d want %0d/%0d", b1, b2, MUL_LAT, DIV_LAT);
    end
  endtask

  task automatic test_flush();
    int nb;
    cyc(1, 3'b100, 0);
    nb = (busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 3'b110, i < 6);
      if (i < 6) begin
        n_vec++;
        if (obs_stall !== 1'b0 || mdu_start !== 1'b0) begin
          n_err++;
          $display("FAIL flush_busy: got stall=%b start=%b want 0/0 at %0d", obs_stall, mdu_start, i);
        end
        if (busy === 1'b1) nb++;
      end
    end
    n_vec++;
    if (nb != MUL_LAT) begin
      n_err++;
      $display("FAIL flush_completes: got busy len %0d want %0d", nb, MUL_LAT);
    end
    n_vec++;
    if (mdu_op !== 3'b110 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL flush_release: got op=%b busy=%b want 110/1", mdu_op, busy);
    end
    for (int i = 0; i < DIV_LAT; i++) cyc(0, 3'b000, 0);
  endtask

  task automatic test_reset_mid();
    cyc(1, 3'b110, 0);
    cyc(0, 3'b000, 0);
    cyc(0, 3'b000, 0);
    req_valid = 1'b1; req_op = 3'b000;
    #1;
    n_vec++;
    if (stall !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_pre: got stall=%b want 1", stall);
    end
    reset = 1'b1;
    #1;
    model_reset();
    n_vec++;
    if (busy !== 1'b0 || stall !== 1'b0 || mdu_start !== 1'b0 || stall_cycles !== 16'd0) begin
      n_err++;
      $display("FAIL rst_mid: got busy=%b stall=%b start=%b cnt=%0d want 0",
               busy, stall, mdu_start, stall_cycles);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    cyc(1, 3'b100, 0);
    n_vec++;
    if (mdu_start !== 1'b1 || mdu_op !== 3'b100 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_resume: got start=%b op=%b busy=%b want 1/100/1", mdu_start, mdu_op, busy);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 9) < 7, 3'($urandom), $urandom_range(0, 9) < 2);
      n_vec++;
      if (obs_stall !== logic'(m_stall) || busy !== logic'(m_rem != 0) ||
          mdu_start !== logic'(m_start) || mdu_op !== m_op || stall_cycles !== 16'(m_cnt)) begin
        n_err++;
        $display("FAIL random[%0d]: got stall=%b busy=%b start=%b op=%b cnt=%0d want %b %b %b %b %0d",
                 i, obs_stall, busy, mdu_start, mdu_op, stall_cycles,
                 m_stall, (m_rem != 0), m_start, m_op, m_cnt);
      end
    end
  endtask

  task automatic test_saturation();
    int ns;
    while (m_cnt < 65534) cyc(1, 3'b110, 0);
    n_vec++;
    if (stall_cycles !== 16'hFFFE) begin
      n_err++;
      $display("FAIL sat_preload: got %0h want fffe", stall_cycles);
    end
    ns = 0;
    for (int i = 0; i < 40 && ns < 3; i++) begin
      cyc(1, 3'b110, 0);
      if (obs_stall === 1'b1) ns++;
    end
    n_vec++;
    if (ns != 3 || stall_cycles !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sat_hold: got cnt=%0h stalls=%0d want ffff/3", stall_cycles, ns);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div_stall();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
